// File: rtl/dense_param_ctrl_pkg.sv
// rtl/dense_param_ctrl_pkg.sv - shared training constants and controller state encoding
package dense_param_ctrl_pkg;

    localparam int N_LEN_DEF     = 16;
    localparam int LR_SHIFT_DEF  = 7;
    localparam int MOM_SHIFT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ZERO   = 3'd1,
        ST_OPT    = 3'd2,
        ST_DONE_Z = 3'd3,
        ST_DONE_U = 3'd4
    } state_e;

endpackage

// File: rtl/dense_optim_lane.sv
// rtl/dense_optim_lane.sv - per-element SGD / momentum update with saturation
module dense_optim_lane
    import dense_param_ctrl_pkg::*;
#(
    parameter int N_LEN     = N_LEN_DEF,
    parameter int LR_SHIFT  = LR_SHIFT_DEF,
    parameter int MOM_SHIFT = MOM_SHIFT_DEF
) (
    input  logic                    mode_i,
    input  logic signed [N_LEN-1:0] w_i,
    input  logic signed [N_LEN-1:0] v_i,
    input  logic signed [N_LEN-1:0] g_i,
    output logic        [N_LEN-1:0] w_o,
    output logic        [N_LEN-1:0] v_o
);

    localparam int AW = N_LEN + 2;
    localparam logic signed [AW-1:0] SAT_MAX = {3'b000, {(N_LEN-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {3'b111, {(N_LEN-1){1'b0}}};

    function automatic logic [N_LEN-1:0] sat(input logic signed [AW-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[N_LEN-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[N_LEN-1:0];
        end
        return x[N_LEN-1:0];
    endfunction

    logic signed [AW-1:0] w_x, v_x, g_x, g_term, v_sum, v_sat_x, w_sum;
    logic        [N_LEN-1:0] v_sat;

    assign w_x    = {{2{w_i[N_LEN-1]}}, w_i};
    assign v_x    = {{2{v_i[N_LEN-1]}}, v_i};
    assign g_x    = {{2{g_i[N_LEN-1]}}, g_i};
    assign g_term = g_x >>> LR_SHIFT;

    // w' in momentum mode is built from the already-saturated v'
    assign v_sum   = v_x - (v_x >>> MOM_SHIFT) - g_term;
    assign v_sat   = sat(v_sum);
    assign v_sat_x = {{2{v_sat[N_LEN-1]}}, v_sat};
    assign w_sum   = mode_i ? (w_x + v_sat_x) : (w_x - g_term);

    assign w_o = sat(w_sum);
    assign v_o = v_sat;

endmodule

// File: rtl/dense_param_ctrl.sv
// rtl/dense_param_ctrl.sv - gradient clear and optimizer sweep controller for dense layer RAMs
module dense_param_ctrl
    import dense_param_ctrl_pkg::*;
#(
    parameter int IN_DIM     = 32,
    parameter int OUT_DIM    = 72,
    parameter int DATA_N     = 6,
    parameter int N_LEN      = N_LEN_DEF,
    parameter int ADDR_WIDTH = 10,
    parameter int LR_SHIFT   = LR_SHIFT_DEF,
    parameter int MOM_SHIFT  = MOM_SHIFT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       zero_grad,
    input  logic                       update,
    input  logic                       optim_mode,
    output logic                       valid_zero_grad,
    output logic                       valid_update,
    output logic                       busy,
    output logic [ADDR_WIDTH-1:0]      param_raddr,
    input  logic [DATA_N*N_LEN-1:0]    w_rdata,
    input  logic [DATA_N*N_LEN-1:0]    v_rdata,
    input  logic [DATA_N*N_LEN-1:0]    grad_rdata,
    output logic [ADDR_WIDTH-1:0]      param_waddr,
    output logic                       w_load,
    output logic                       v_load,
    output logic                       grad_load,
    output logic [DATA_N*N_LEN-1:0]    w_wdata,
    output logic [DATA_N*N_LEN-1:0]    v_wdata,
    output logic [DATA_N*N_LEN-1:0]    grad_wdata
);

    localparam int DEPTH = IN_DIM * OUT_DIM / DATA_N;
    localparam int DW    = DATA_N * N_LEN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_done_q, rd_done_d;
    logic                  mode_q, mode_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    logic [DW-1:0]         s2_w_q, s2_w_d, s2_v_q, s2_v_d;
    logic [DW-1:0]         lane_w, lane_v;

    logic                  w_load_c, v_load_c, grad_load_c, valid_z_c, valid_u_c;
    logic [ADDR_WIDTH-1:0] waddr_c;

    for (genvar i = 0; i < DATA_N; i++) begin : g_lane
        dense_optim_lane #(
            .N_LEN     (N_LEN),
            .LR_SHIFT  (LR_SHIFT),
            .MOM_SHIFT (MOM_SHIFT)
        ) u_lane (
            .mode_i (mode_q),
            .w_i    (w_rdata[i*N_LEN +: N_LEN]),
            .v_i    (v_rdata[i*N_LEN +: N_LEN]),
            .g_i    (grad_rdata[i*N_LEN +: N_LEN]),
            .w_o    (lane_w[i*N_LEN +: N_LEN]),
            .v_o    (lane_v[i*N_LEN +: N_LEN])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_done_d   = rd_done_q;
        mode_d      = mode_q;
        s1_valid_d  = 1'b0;
        s1_addr_d   = cnt_q;
        s2_valid_d  = 1'b0;
        s2_addr_d   = s1_addr_q;
        s2_w_d      = s1_valid_q ? lane_w : '0;
        s2_v_d      = s1_valid_q ? lane_v : '0;
        w_load_c    = 1'b0;
        v_load_c    = 1'b0;
        grad_load_c = 1'b0;
        valid_z_c   = 1'b0;
        valid_u_c   = 1'b0;
        waddr_c     = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                rd_done_d = 1'b0;
                if (update) begin
                    state_d = ST_OPT;
                    mode_d  = optim_mode;
                end else if (zero_grad) begin
                    state_d = ST_ZERO;
                end
            end
            ST_ZERO: begin
                if (!zero_grad) begin
                    state_d = ST_IDLE;
                end else begin
                    grad_load_c = 1'b1;
                    waddr_c     = cnt_q;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_DONE_Z;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OPT: begin
                // dropping the request kills every pending stage at once
                if (!update) begin
                    state_d = ST_IDLE;
                end else begin
                    if (!rd_done_q) begin
                        s1_valid_d = 1'b1;
                        if (cnt_q == LAST_ADDR) begin
                            rd_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    s2_valid_d = s1_valid_q;
                    if (s2_valid_q) begin
                        w_load_c = 1'b1;
                        v_load_c = mode_q;
                        waddr_c  = s2_addr_q;
                        if (s2_addr_q == LAST_ADDR) begin
                            state_d = ST_DONE_U;
                        end
                    end
                end
            end
            ST_DONE_Z: begin
                valid_z_c = zero_grad;
                if (!zero_grad) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE_U: begin
                valid_u_c = update;
                if (!update) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_done_q  <= 1'b0;
            mode_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_w_q     <= '0;
            s2_v_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_done_q  <= rd_done_d;
            mode_q     <= mode_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_w_q     <= s2_w_d;
            s2_v_q     <= s2_v_d;
        end
    end

    assign busy            = rst_n && (state_q != ST_IDLE);
    assign valid_zero_grad = rst_n && valid_z_c;
    assign valid_update    = rst_n && valid_u_c;
    assign w_load          = rst_n && w_load_c;
    assign v_load          = rst_n && v_load_c;
    assign grad_load       = rst_n && grad_load_c;
    assign param_raddr     = (state_q == ST_OPT) ? cnt_q : '0;
    assign param_waddr     = waddr_c;
    assign w_wdata         = s2_w_q;
    assign v_wdata         = s2_v_q;
    assign grad_wdata      = '0;

endmodule

// File: tb/tb_dense_param_ctrl.sv
// tb/tb_dense_param_ctrl.sv - directed self-checking bench for dense_param_ctrl
module tb_dense_param_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 6;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n, zero_grad, update, optim_mode;
    logic          valid_zero_grad, valid_update, busy;
    logic [AW-1:0] param_raddr, param_waddr;
    logic [DW-1:0] w_rdata, v_rdata, grad_rdata;
    logic          w_load, v_load, grad_load;
    logic [DW-1:0] w_wdata, v_wdata, grad_wdata;

    logic [DW-1:0] w_mem [8];
    logic [DW-1:0] v_mem [8];
    logic [DW-1:0] g_mem [8];
    logic [DW-1:0] w_init, v_init, g_init;
    logic          do_init;
    int            wload_cnt, vload_cnt;
    int            n_pass, n_total;

    typedef struct {
        logic        mode;
        logic [15:0] w, v, g, ew, ev;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    dense_param_ctrl #(
        .IN_DIM(4), .OUT_DIM(3), .DATA_N(2), .N_LEN(16),
        .ADDR_WIDTH(AW), .LR_SHIFT(2), .MOM_SHIFT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .zero_grad(zero_grad), .update(update),
        .optim_mode(optim_mode), .valid_zero_grad(valid_zero_grad),
        .valid_update(valid_update), .busy(busy), .param_raddr(param_raddr),
        .w_rdata(w_rdata), .v_rdata(v_rdata), .grad_rdata(grad_rdata),
        .param_waddr(param_waddr), .w_load(w_load), .v_load(v_load),
        .grad_load(grad_load), .w_wdata(w_wdata), .v_wdata(v_wdata),
        .grad_wdata(grad_wdata)
    );

    // RAM model: synchronous 1-cycle read, write on load
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 8; i++) begin
                w_mem[i] <= w_init;
                v_mem[i] <= v_init;
                g_mem[i] <= g_init;
            end
            wload_cnt <= 0;
            vload_cnt <= 0;
        end else begin
            if (w_load)    w_mem[param_waddr] <= w_wdata;
            if (v_load)    v_mem[param_waddr] <= v_wdata;
            if (grad_load) g_mem[param_waddr] <= grad_wdata;
            if (w_load)    wload_cnt <= wload_cnt + 1;
            if (v_load)    vload_cnt <= vload_cnt + 1;
        end
        w_rdata    <= w_mem[param_raddr];
        v_rdata    <= v_mem[param_raddr];
        grad_rdata <= g_mem[param_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic load_mem(input logic [15:0] w, input logic [15:0] v, input logic [15:0] g);
        w_init  = {w, w};
        v_init  = {v, v};
        g_init  = {g, g};
        do_init = 1'b1;
        tick();
        do_init = 1'b0;
    endtask

    task automatic run_update(input logic m);
        int n;
        optim_mode = m;
        update     = 1'b1;
        n = 0;
        while (!valid_update && n < 60) begin
            tick();
            n++;
        end
        chk("update_done", 32'(valid_update), 32'd1);
        update = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int gl, n;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; zero_grad = 1'b0; update = 1'b0; optim_mode = 1'b0;
        do_init = 1'b0; w_init = '0; v_init = '0; g_init = '0;
        load_mem(16'h0, 16'h0, 16'h0);
        repeat (3) tick();

        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_loads", 32'({w_load, v_load, grad_load}), 32'd0);
        chk("rst_valid", 32'({valid_zero_grad, valid_update}), 32'd0);
        chk("rst_addr",  32'({param_raddr, param_waddr}), 32'd0);
        chk("rst_wdata", w_wdata | v_wdata | grad_wdata, 32'd0);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{1'b0, 16'h0100, 16'h1234, 16'h0040, 16'h00F0, 16'h1234};
        vecs[1] = '{1'b0, 16'h7FF0, 16'h0001, 16'h8000, 16'h7FFF, 16'h0001};
        vecs[2] = '{1'b0, 16'h8010, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000};
        vecs[3] = '{1'b0, 16'h0000, 16'h5555, 16'hFFFF, 16'h0001, 16'h5555};
        vecs[4] = '{1'b1, 16'h0100, 16'h0080, 16'h0040, 16'h0160, 16'h0060};
        vecs[5] = '{1'b1, 16'h7000, 16'h7FF8, 16'h8000, 16'h7FFF, 16'h7FFF};
        vecs[6] = '{1'b1, 16'h0010, 16'hFF00, 16'h0100, 16'hFEF0, 16'hFEE0};
        vecs[7] = '{1'b1, 16'h1000, 16'h8000, 16'h7FFC, 16'h9000, 16'h8000};

        for (int k = 0; k < 8; k++) begin
            load_mem(vecs[k].w, vecs[k].v, vecs[k].g);
            run_update(vecs[k].mode);
            for (int a = 0; a < DEPTH; a++) begin
                chk($sformatf("vec%0d_w%0d", k, a), w_mem[a], {vecs[k].ew, vecs[k].ew});
                chk($sformatf("vec%0d_v%0d", k, a), v_mem[a], {vecs[k].ev, vecs[k].ev});
            end
            chk($sformatf("vec%0d_wload_cnt", k), 32'(wload_cnt), 32'd6);
            chk($sformatf("vec%0d_vload_cnt", k), 32'(vload_cnt), vecs[k].mode ? 32'd6 : 32'd0);
        end

        // zero sweep timing
        load_mem(16'h1111, 16'h2222, 16'hABCD);
        zero_grad = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("zero_load_c%0d", c), 32'(grad_load), 32'(c >= 1 && c <= 6));
            if (c >= 1 && c <= 6) begin
                chk($sformatf("zero_addr_c%0d", c), 32'(param_waddr), 32'(c - 1));
                chk($sformatf("zero_wdata_c%0d", c), grad_wdata, 32'd0);
            end
            chk($sformatf("zero_valid_c%0d", c), 32'(valid_zero_grad), 32'(c >= 7));
            tick();
        end
        zero_grad = 1'b0;
        tick();
        chk("zero_idle_busy", 32'(busy), 32'd0);
        for (int a = 0; a < DEPTH; a++) chk($sformatf("zero_mem%0d", a), g_mem[a], 32'd0);

        // update sweep timing
        load_mem(16'h0100, 16'h0080, 16'h0040);
        optim_mode = 1'b0;
        update     = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 6) chk($sformatf("opt_raddr_c%0d", c), 32'(param_raddr), 32'(c - 1));
            chk($sformatf("opt_wload_c%0d", c), 32'(w_load), 32'(c >= 3 && c <= 8));
            if (c >= 3 && c <= 8) chk($sformatf("opt_waddr_c%0d", c), 32'(param_waddr), 32'(c - 3));
            if (c == 3) chk("opt_wdata_c3", w_wdata, 32'h00F000F0);
            chk($sformatf("opt_vload_c%0d", c), 32'(v_load), 32'd0);
            chk($sformatf("opt_valid_c%0d", c), 32'(valid_update), 32'(c == 9));
            chk($sformatf("opt_busy_c%0d", c), 32'(busy), 32'(c >= 1));
            tick();
        end
        update = 1'b0;
        tick();
        tick();

        // abort at cycle 3 then re-request at cycle 5
        load_mem(16'h0100, 16'h0080, 16'h0040);
        optim_mode = 1'b0;
        update     = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c == 3) update = 1'b0;
            if (c == 5) update = 1'b1;
            @(negedge clk);
            if (c >= 3) chk($sformatf("abort_wload_c%0d", c), 32'(w_load), 32'd0);
            if (c == 4) chk("abort_busy_c4", 32'(busy), 32'd0);
            if (c == 6) chk("abort_reraddr_c6", 32'(param_raddr), 32'd0);
            if (c == 7) chk("abort_reraddr_c7", 32'(param_raddr), 32'd1);
            tick();
        end
        n = 0;
        while (!valid_update && n < 40) begin
            tick();
            n++;
        end
        chk("abort_redo_done", 32'(valid_update), 32'd1);
        update = 1'b0;
        tick();
        tick();

        // reset asserted mid-sweep
        optim_mode = 1'b0;
        update     = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c == 4) rst_n = 1'b0;
            if (c == 5) begin
                rst_n  = 1'b1;
                update = 1'b0;
            end
            @(negedge clk);
            if (c == 3) chk("rstmid_wload_c3", 32'(w_load), 32'd1);
            if (c == 5) begin
                chk("rstmid_wload_c5", 32'(w_load), 32'd0);
                chk("rstmid_busy_c5", 32'(busy), 32'd0);
                chk("rstmid_waddr_c5", 32'(param_waddr), 32'd0);
                chk("rstmid_wdata_c5", w_wdata, 32'd0);
            end
            if (c == 6) chk("rstmid_busy_c6", 32'(busy), 32'd0);
            tick();
        end

        // priority: update wins, zero waits until update drops
        load_mem(16'h0100, 16'h0080, 16'h0040);
        optim_mode = 1'b0;
        update     = 1'b1;
        zero_grad  = 1'b1;
        tick(); tick(); tick();
        chk("prio_wload_c3", 32'(w_load), 32'd1);
        gl = 0;
        n  = 0;
        while (!valid_update && n < 40) begin
            if (grad_load) gl++;
            tick();
            n++;
        end
        chk("prio_update_done", 32'(valid_update), 32'd1);
        chk("prio_no_gradload", 32'(gl), 32'd0);
        update = 1'b0;
        n = 0;
        while (!grad_load && n < 10) begin
            tick();
            n++;
        end
        chk("prio_zero_start", 32'(grad_load), 32'd1);
        chk("prio_zero_addr0", 32'(param_waddr), 32'd0);
        n = 0;
        while (!valid_zero_grad && n < 20) begin
            tick();
            n++;
        end
        chk("prio_zero_done", 32'(valid_zero_grad), 32'd1);
        zero_grad = 1'b0;
        tick();
        chk("prio_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dense_param_ctrl.md
DENSE_PARAM_CTRL -- requirements
Module: dense_param_ctrl

Interface
REQ-001 Parameter IN_DIM, default 32: input feature count of the dense layer.
REQ-002 Parameter OUT_DIM, default 72: output feature count.
REQ-003 Parameter DATA_N, default 6: elements packed per RAM word; IN_DIM*OUT_DIM SHALL be a multiple of DATA_N.
REQ-004 Parameter N_LEN, default 16: signed fixed-point element width.
REQ-005 Parameter ADDR_WIDTH, default 10: RAM address width, SHALL satisfy 2^ADDR_WIDTH > DEPTH, where DEPTH = IN_DIM*OUT_DIM/DATA_N.
REQ-006 Parameter LR_SHIFT, default 7: learning rate is 2^-LR_SHIFT.
REQ-007 Parameter MOM_SHIFT, default 3: momentum is beta = 1 - 2^-MOM_SHIFT.
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 rst_n  in  1  reset; one clock, reset is synchronous and active-low.
REQ-010 zero_grad  in  1  level request, held until valid_zero_grad: clear gradient RAM.
REQ-011 update  in  1  level request, held until valid_update: run optimizer sweep.
REQ-012 optim_mode  in  1  0 = plain SGD, 1 = momentum SGD; sampled when the update sweep starts.
REQ-013 valid_zero_grad / valid_update  out  1 each  completion flags.
REQ-014 busy  out  1  high in any non-IDLE state.
REQ-015 param_raddr  out  ADDR_WIDTH  shared read address to W, V and grad RAMs.
REQ-016 w_rdata, v_rdata, grad_rdata  in  DATA_N*N_LEN each  RAM read data, 1-cycle synchronous read.
REQ-017 param_waddr  out  ADDR_WIDTH  shared write address.
REQ-018 w_load, v_load, grad_load  out  1 each  write enables.
REQ-019 w_wdata, v_wdata, grad_wdata  out  DATA_N*N_LEN each  write data.

Function
REQ-020 FSM states: IDLE, ZERO, OPT, DONE_Z, DONE_U. In IDLE, update has priority over zero_grad when both are high.
REQ-021 ZERO: grad_load is high for exactly DEPTH consecutive cycles starting the cycle after entry, with param_waddr running 0..DEPTH-1 ascending and grad_wdata all zero. The FSM then enters DONE_Z.
REQ-022 OPT: param_raddr issues 0..DEPTH-1 on consecutive cycles starting the cycle after entry. The write for address k occurs exactly 2 cycles after its read (read, register, write). The FSM enters DONE_U the cycle after the last write.
REQ-023 SGD lane: w' = w - (grad >>> LR_SHIFT). In this mode w_load is asserted and v_load is never asserted.
REQ-024 Momentum lane: v' = v - (v >>> MOM_SHIFT) - (grad >>> LR_SHIFT), then w' = w + v'. w_load and v_load are asserted together.
REQ-025 Arithmetic is performed at N_LEN+2 bits, and each result is saturated to the signed N_LEN range before being written. The v' value used for w' is the saturated one.
REQ-026 DONE_Z/DONE_U: the corresponding valid is high while its request stays high. When the request drops, the FSM returns to IDLE on the next cycle.
REQ-027 Abort: if the active request deasserts before its DONE state is reached, then from that same cycle no further load is asserted, in-flight writes are dropped, and the FSM goes to IDLE next cycle. A later request restarts at address 0.
REQ-028 Requests raised while busy with the other operation are ignored until the FSM returns to IDLE.
REQ-029 Wrap-around: the address counters stop at DEPTH-1 and never wrap within a sweep.

Reset
REQ-030 While rst_n is low at a clock edge: the FSM goes to IDLE, counters and pipeline registers clear, and all outputs are 0.
REQ-031 A reset asserted mid-sweep aborts the sweep with no write on the following cycle.

Structure
REQ-032 N_LEN, fixed-point constants and the FSM state encoding SHALL live in the shared training constants header.
REQ-033 Per-element arithmetic SHALL be one sub-module, dense_optim_lane, instantiated DATA_N times. The controller holds only the FSM, counters and pipeline registers.

Verification (IN_DIM=4, OUT_DIM=3, DATA_N=2, DEPTH=6, N_LEN=16, LR_SHIFT=2, MOM_SHIFT=3)
REQ-034 Zero: zero_grad is held from cycle 0 -> grad_load is high in cycles 1..6 with addr 0..5, and valid_zero_grad is high from cycle 7.
REQ-035 SGD: w=0x0100, grad=0x0040 -> w_wdata=0x00F0, and v_load stays 0 throughout.
REQ-036 Momentum: v=0x0080, grad=0x0040, w=0x0100 -> v_wdata=0x0060 and w_wdata=0x0160.
REQ-037 Saturation in SGD mode: w=0x7FF0, grad=0x8000 -> w_wdata=0x7FFF.
REQ-038 Abort: update is dropped at cycle 3 -> no w_load from cycle 3 onward, busy is low at cycle 4, and a re-request reads address 0 first.
REQ-039 Priority: zero_grad and update are both high in IDLE -> the OPT sweep runs, and ZERO starts only after update drops.
